// File: rtl/checkpoint_ctrl_pkg.sv
// checkpoint_ctrl_pkg: shared checkpoint types and constants; RENAME_WIDTH sets the rename group width (default 2).
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 2
`endif
package checkpoint_ctrl_pkg;
  localparam int CP_NUM = 4;
  localparam int CP_IDX_W = $clog2(CP_NUM);
  localparam int RW = `RENAME_WIDTH;
  typedef logic [CP_IDX_W-1:0] cp_index_t;
  typedef enum logic [1:0] {CP_RUN, CP_RECOVER, CP_FLUSH} cp_state_e;
endpackage

// File: rtl/checkpoint_ctrl.sv
// checkpoint_ctrl: rename-map checkpoint allocator and mispredict recovery sequencer; CHECKPOINT_PERF_EN adds perf counters.
module checkpoint_ctrl
  import checkpoint_ctrl_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                rn_fire,
  input  logic [RW-1:0]       br_valid,
  input  logic                res_valid,
  input  cp_index_t           res_idx,
  input  logic                res_mispred,
  output logic                check,
  output cp_index_t           check_idx,
  output logic [RW-1:0]       check_flag,
  output cp_index_t           br_tag,
  output logic                recover,
  output cp_index_t           recover_idx,
  output logic                cp_stall,
`ifdef CHECKPOINT_PERF_EN
  output logic [31:0]         perf_full_cycles,
  output logic [31:0]         perf_recovers,
`endif
  output logic [CP_IDX_W:0]   cp_count
);
  cp_state_e state_q, state_d;
  cp_index_t head_q, head_d, tail_q, tail_d, rec_q, keep;
  logic [CP_IDX_W:0] cnt_q, cnt_d, span;
  logic [CP_NUM-1:0] live_q, live_d, done_q, done_d;
  logic mis_acc, full, run, rel;
  always_comb begin
    mis_acc = res_valid & res_mispred & live_q[res_idx];
    full = cnt_q == (CP_IDX_W+1)'(CP_NUM);
    run = state_q == CP_RUN;
    check = run & rn_fire & |br_valid & !full & !mis_acc;
    cp_stall = !run | (|br_valid & (full | mis_acc));
    rel = live_q[head_q] & done_q[head_q] & !(mis_acc & res_idx == head_q);
    keep = res_idx - head_q;
    // span counts slots res_idx..tail-1 from the count, so a full buffer frees all slots
    span = cnt_q - {1'b0, keep};
    live_d = live_q;
    done_d = done_q;
    if (rel) live_d[head_q] = 1'b0;
    if (res_valid & !res_mispred & live_q[res_idx]) done_d[res_idx] = 1'b1;
    if (check) begin
      live_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
    end
    for (int i = 0; i < CP_NUM; i++)
      if (mis_acc && {1'b0, cp_index_t'(i) - res_idx} < span) live_d[i] = 1'b0;
    head_d = head_q + cp_index_t'(rel);
    tail_d = mis_acc ? res_idx : tail_q + cp_index_t'(check);
    cnt_d = mis_acc ? {1'b0, keep} - (CP_IDX_W+1)'(rel)
                    : cnt_q + (CP_IDX_W+1)'(check) - (CP_IDX_W+1)'(rel);
    state_d = mis_acc ? CP_RECOVER : state_q == CP_RECOVER ? CP_FLUSH : CP_RUN;
    recover = (state_q == CP_RECOVER) & !reset;
    recover_idx = recover ? rec_q : '0;
    check_flag = check ? br_valid : '0;
    check_idx = tail_q;
    br_tag = tail_q;
    cp_count = cnt_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CP_RUN;
      head_q <= '0;
      tail_q <= '0;
      rec_q <= '0;
      cnt_q <= '0;
      live_q <= '0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      rec_q <= mis_acc ? res_idx : rec_q;
      cnt_q <= cnt_d;
      live_q <= live_d;
      done_q <= done_d;
    end
  end
`ifdef CHECKPOINT_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_full_cycles <= '0;
      perf_recovers <= '0;
    end else begin
      if (run && full && |br_valid && !(&perf_full_cycles)) perf_full_cycles <= perf_full_cycles + 32'd1;
      if (recover && !(&perf_recovers)) perf_recovers <= perf_recovers + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_checkpoint_ctrl.sv
// tb_checkpoint_ctrl: directed self-checking bench for checkpoint_ctrl.
module tb_checkpoint_ctrl;
  import checkpoint_ctrl_pkg::*;
  logic clock = 0, reset = 1, rn_fire = 0, res_valid = 0, res_mispred = 0;
  logic [RW-1:0] br_valid = '0;
  cp_index_t res_idx = '0;
  logic check, recover, cp_stall;
  cp_index_t check_idx, br_tag, recover_idx;
  logic [RW-1:0] check_flag;
  logic [CP_IDX_W:0] cp_count;
`ifdef CHECKPOINT_PERF_EN
  logic [31:0] perf_full_cycles, perf_recovers;
`endif
  int total = 0, bad = 0;
  always #5 clock = ~clock;
  checkpoint_ctrl dut (
    .clock(clock), .reset(reset), .rn_fire(rn_fire), .br_valid(br_valid),
    .res_valid(res_valid), .res_idx(res_idx), .res_mispred(res_mispred),
    .check(check), .check_idx(check_idx), .check_flag(check_flag), .br_tag(br_tag),
    .recover(recover), .recover_idx(recover_idx), .cp_stall(cp_stall),
`ifdef CHECKPOINT_PERF_EN
    .perf_full_cycles(perf_full_cycles), .perf_recovers(perf_recovers),
`endif
    .cp_count(cp_count)
  );
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic do_reset;
    reset = 1;
    rn_fire = 0;
    br_valid = '0;
    res_valid = 0;
    res_mispred = 0;
    tick;
    tick;
    reset = 0;
    #1;
  endtask
  task automatic alloc(input int idx);
    rn_fire = 1;
    br_valid = RW'(1);
    #1;
    chk("alloc_check", 32'(check), 1);
    chk("alloc_idx", 32'(check_idx), 32'(idx));
    chk("alloc_tag", 32'(br_tag), 32'(idx));
    tick;
    rn_fire = 0;
    br_valid = '0;
  endtask
  task automatic resolve(input int idx, input logic mis);
    res_valid = 1;
    res_idx = cp_index_t'(idx);
    res_mispred = mis;
  endtask
  initial begin
    do_reset;
    chk("rst_check", 32'(check), 0);
    chk("rst_count", 32'(cp_count), 0);
    chk("rst_stall", 32'(cp_stall), 0);
    chk("rst_recover", 32'(recover), 0);
    chk("rst_idx", 32'(check_idx), 0);
    // fill all four slots
    for (int i = 0; i < 4; i++) alloc(i);
    chk("full_count", 32'(cp_count), 4);
    rn_fire = 1;
    br_valid = RW'(1);
    #1;
    chk("full_stall", 32'(cp_stall), 1);
    chk("full_check", 32'(check), 0);
    chk("full_flag", 32'(check_flag), 0);
    br_valid = '0;
    #1;
    chk("full_nobr_stall", 32'(cp_stall), 0);
    rn_fire = 0;
    // out-of-order resolve
    resolve(2, 0); tick;
    resolve(0, 0); tick;
    res_valid = 0;
    chk("ooo_before_rel", 32'(cp_count), 4);
    tick;
    chk("ooo_count3", 32'(cp_count), 3);
    resolve(1, 0); tick;
    res_valid = 0;
    tick;
    chk("ooo_count2", 32'(cp_count), 2);
    tick;
    chk("ooo_count1", 32'(cp_count), 1);
    tick;
    chk("ooo_hold", 32'(cp_count), 1);
    // mispredict idx=1, head=0, tail=3
    do_reset;
    for (int i = 0; i < 3; i++) alloc(i);
    resolve(1, 1);
    tick;
    res_valid = 0;
    chk("mp_recover", 32'(recover), 1);
    chk("mp_recover_idx", 32'(recover_idx), 1);
    chk("mp_stall1", 32'(cp_stall), 1);
    tick;
    chk("mp_recover_off", 32'(recover), 0);
    chk("mp_stall2", 32'(cp_stall), 1);
    tick;
    chk("mp_stall_free", 32'(cp_stall), 0);
    chk("mp_count", 32'(cp_count), 1);
    alloc(1);
    alloc(2);
    chk("mp_count3", 32'(cp_count), 3);
    // mispredict idx=2 colliding with an allocation
    resolve(2, 1);
    rn_fire = 1;
    br_valid = RW'(1);
    #1;
    chk("col_check", 32'(check), 0);
    chk("col_stall", 32'(cp_stall), 1);
    tick;
    rn_fire = 0;
    br_valid = '0;
    res_valid = 0;
    chk("col_recover_idx", 32'(recover_idx), 2);
    tick;
    tick;
    chk("col_count", 32'(cp_count), 2);
    chk("col_tail", 32'(check_idx), 2);
    // mispredicts arriving during FLUSH
    do_reset;
    for (int i = 0; i < 4; i++) alloc(i);
    resolve(1, 1); tick;
    res_valid = 0; tick;
    resolve(3, 1); tick;
    res_valid = 0;
    chk("stale_recover", 32'(recover), 0);
    chk("stale_stall", 32'(cp_stall), 0);
    chk("stale_count", 32'(cp_count), 1);
    chk("stale_tail", 32'(check_idx), 1);
    alloc(1);
    alloc(2);
    resolve(2, 1); tick;
    res_valid = 0; tick;
    resolve(0, 1); tick;
    res_valid = 0;
    chk("restart_recover", 32'(recover), 1);
    chk("restart_idx", 32'(recover_idx), 0);
    chk("restart_count", 32'(cp_count), 0);
    chk("restart_tail", 32'(check_idx), 0);
    tick;
    tick;
    chk("restart_run", 32'(cp_stall), 0);
    // full buffer with head=2, mispredict on head
    do_reset;
    for (int i = 0; i < 4; i++) alloc(i);
    resolve(0, 0); tick;
    resolve(1, 0); tick;
    res_valid = 0; tick;
    chk("wrap_count2", 32'(cp_count), 2);
    alloc(0);
    alloc(1);
    chk("wrap_full", 32'(cp_count), 4);
    resolve(2, 1); tick;
    res_valid = 0;
    chk("wrap_count0", 32'(cp_count), 0);
    chk("wrap_tail", 32'(check_idx), 2);
    chk("wrap_recover_idx", 32'(recover_idx), 2);
    reset = 1;
    #1;
    chk("rst_mid_recover", 32'(recover), 0);
    tick;
    reset = 0;
    #1;
    chk("rst2_recover", 32'(recover), 0);
    chk("rst2_stall", 32'(cp_stall), 0);
    chk("rst2_count", 32'(cp_count), 0);
    chk("rst2_idx", 32'(check_idx), 0);
    chk("rst2_check", 32'(check), 0);
    // resolve on a freed slot is ignored
    resolve(1, 1); tick;
    res_valid = 0;
    chk("ign_recover", 32'(recover), 0);
    chk("ign_count", 32'(cp_count), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
